// File: rtl/sayuru_pkg.sv
// Shared constants, request bundle and helpers for the sayuru backing memory.
// Widths here match the sayuru cache's downstream data port.
package sayuru_pkg;
    localparam int SAYURU_ADDR_WIDTH = 16;
    localparam int SAYURU_DATA_WIDTH = 32;
    localparam int BYTES_PER_WORD    = SAYURU_DATA_WIDTH / 8;
    localparam int WORD_OFFSET_BITS  = $clog2(BYTES_PER_WORD);

    typedef struct packed {
        logic [SAYURU_ADDR_WIDTH-1:0] addr;
        logic                         we;
        logic [BYTES_PER_WORD-1:0]    be;
        logic [SAYURU_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    // Byte address to word index; callers fold it into their array depth.
    function automatic logic [SAYURU_ADDR_WIDTH-1:0] word_index(input logic [SAYURU_ADDR_WIDTH-1:0] addr);
        return addr >> WORD_OFFSET_BITS;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction
endpackage

// File: rtl/sayuru_resp_pipe.sv
// Fixed-latency response delay line of {valid, rdata} with an occupancy count.
// Stage 0 loads in the grant cycle; the last stage drives the response.
module sayuru_resp_pipe
    import sayuru_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int DATA_WIDTH = SAYURU_DATA_WIDTH,
    parameter int OCC_WIDTH  = $clog2(LATENCY + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [OCC_WIDTH-1:0]  occupancy
);
    logic [LATENCY-1:0]    valid_r;
    logic [DATA_WIDTH-1:0] data_r [LATENCY];
    logic [OCC_WIDTH-1:0]  occ_r;

    // Shift valid/data one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_r[i] <= '0;
            end
        end else begin
            valid_r[0] <= in_valid;
            data_r[0]  <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                valid_r[i] <= valid_r[i-1];
                data_r[i]  <= data_r[i-1];
            end
        end
    end

    // Entries in flight: enter on in_valid, leave on out_valid, both cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_r <= '0;
        end else begin
            case ({in_valid, valid_r[LATENCY-1]})
                2'b10:   occ_r <= occ_r + OCC_WIDTH'(1);
                2'b01:   occ_r <= occ_r - OCC_WIDTH'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign out_valid = valid_r[LATENCY-1];
    assign out_data  = data_r[LATENCY-1];
    assign occupancy = occ_r;
endmodule

// File: rtl/sayuru_backing_mem.sv
// Latency-programmable backing memory behind the sayuru cache: array, byte-enable
// merge, bounded-outstanding grant and saturating performance counters.
module sayuru_backing_mem
    import sayuru_pkg::*;
#(
    parameter int ADDR_WIDTH      = SAYURU_ADDR_WIDTH,
    parameter int DATA_WIDTH      = SAYURU_DATA_WIDTH,
    parameter int MEM_WORDS       = 1024,
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic [31:0]             read_count,
    output logic [31:0]             write_count,
    output logic [31:0]             stall_count
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int OCC_W = $clog2(LATENCY + 1);

    logic [DATA_WIDTH-1:0] mem_r [MEM_WORDS];
    mem_req_t              req_s;
    logic [IDX_W-1:0]      idx_s;
    logic                  grant_s;
    logic                  retiring_s;
    logic [OCC_W-1:0]      occupancy_s;
    logic [DATA_WIDTH-1:0] pipe_data_s;
    logic [31:0]           read_count_r;
    logic [31:0]           write_count_r;
    logic [31:0]           stall_count_r;

    // Bundle the request; upper address bits beyond the array depth alias.
    always_comb begin
        req_s.addr  = data_addr_i;
        req_s.we    = data_we_i;
        req_s.be    = data_be_i;
        req_s.wdata = data_wdata_i;
        idx_s       = IDX_W'(word_index(req_s.addr));
    end

    // A retiring response frees its slot in the same cycle, so grant may reuse it.
    always_comb begin
        grant_s = 1'b0;
        if (rst) begin
            grant_s = 1'b0;
        end else if (data_req_i && ((occupancy_s < OCC_W'(MAX_OUTSTANDING)) || retiring_s)) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Byte-masked write at the end of the grant cycle; contents survive reset.
    always_ff @(posedge clk) begin
        if (grant_s && req_s.we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (req_s.be[b]) begin
                    mem_r[idx_s][b*8 +: 8] <= req_s.wdata[b*8 +: 8];
                end
            end
        end
    end

    // Reads capture the whole word now; writes and idle cycles carry zero.
    always_comb begin
        pipe_data_s = '0;
        if (grant_s && !req_s.we) begin
            pipe_data_s = mem_r[idx_s];
        end else begin
            pipe_data_s = '0;
        end
    end

    sayuru_resp_pipe #(
        .LATENCY    (LATENCY),
        .DATA_WIDTH (DATA_WIDTH),
        .OCC_WIDTH  (OCC_W)
    ) u_resp_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (grant_s),
        .in_data   (pipe_data_s),
        .out_valid (retiring_s),
        .out_data  (data_rdata_o),
        .occupancy (occupancy_s)
    );

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_count_r  <= 32'd0;
            write_count_r <= 32'd0;
            stall_count_r <= 32'd0;
        end else begin
            if (grant_s && !req_s.we) begin
                read_count_r <= sat_inc(read_count_r);
            end
            if (grant_s && req_s.we) begin
                write_count_r <= sat_inc(write_count_r);
            end
            if (data_req_i && !grant_s) begin
                stall_count_r <= sat_inc(stall_count_r);
            end
        end
    end

    assign data_gnt_o    = grant_s;
    assign data_rvalid_o = retiring_s;
    assign read_count    = read_count_r;
    assign write_count   = write_count_r;
    assign stall_count   = stall_count_r;
endmodule
